// File: rtl/uart_bus_initiator_pkg.sv
// Shared definitions for the UART bus initiator: protocol tags, FSM states,
// RX byte classes and the protocol byte builder.
package uart_bus_initiator_pkg;

   // Host -> remote tags
   localparam logic [2:0] TAG_ADDR    = 3'b001;
   localparam logic [2:0] TAG_DATA    = 3'b010;
   localparam logic [2:0] TAG_EXEC_WR = 3'b011;
   localparam logic [2:0] TAG_EXEC_RD = 3'b100;
   // Remote -> host tags
   localparam logic [2:0] TAG_RDATA   = 3'b101;
   localparam logic [2:0] TAG_WACK    = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_ADDR,
      ST_SEND_DATA,
      ST_SEND_EXEC,
      ST_WAIT_RESP,
      ST_RESP_LO,
      ST_DONE
   } state_t;

   // Classification of a received byte, one per rx strobe
   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_STREAM,
      CLS_RDATA,
      CLS_WACK,
      CLS_OTHER
   } cls_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } req_t;

   // Protocol bytes always carry bit7=1 so the remote can split them from the stream
   function automatic logic [7:0] build_byte(input logic [2:0] tag, input logic [3:0] nib);
      return {1'b1, tag, nib};
   endfunction

endpackage

// File: rtl/uart_resp_decoder.sv
// Classifies each received byte into stream / RDATA / WACK / other and
// registers it, so every consumer sees the class one cycle after the rx pulse.
module uart_resp_decoder
   import uart_bus_initiator_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_byte,
   input  logic       i_valid,
   output cls_t       o_cls,
   output logic [6:0] o_payload
);

   // One-cycle class strobe plus the low seven bits of the byte
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_cls     <= CLS_NONE;
         o_payload <= '0;
      end else begin
         o_cls <= CLS_NONE;
         if (i_valid) begin
            o_payload <= i_byte[6:0];
            if (!i_byte[7]) begin
               o_cls <= CLS_STREAM;
            end else begin
               case (i_byte[6:4])
                  TAG_RDATA: o_cls <= CLS_RDATA;
                  TAG_WACK:  o_cls <= CLS_WACK;
                  default:   o_cls <= CLS_OTHER;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples mid-bit after a synchronised falling edge and
// pulses o_received_pulse for one cycle when a frame with a valid stop bit lands.
module uart_rx #(
   parameter int TICK = 217
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_received_pulse
);
   localparam int CW = $clog2(TICK + 1);

   logic [1:0]    sync;
   logic          rx_s;
   logic          busy;
   logic [3:0]    bit_cnt;
   logic [CW-1:0] tick_cnt;
   logic [7:0]    shift;

   assign rx_s = sync[1];

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge i_clk) begin
      if (i_reset) sync <= 2'b11;
      else         sync <= {sync[0], i_rx};
   end

   // Frame sampler: half a bit to the start-bit centre, then a full bit per sample
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy             <= 1'b0;
         bit_cnt          <= '0;
         tick_cnt         <= '0;
         shift            <= '0;
         o_data           <= '0;
         o_received_pulse <= 1'b0;
      end else begin
         o_received_pulse <= 1'b0;
         if (!busy) begin
            if (!rx_s) begin
               busy     <= 1'b1;
               bit_cnt  <= '0;
               tick_cnt <= '0;
            end
         end else if (bit_cnt == 4'd0) begin
            if (tick_cnt == CW'(TICK / 2 - 1)) begin
               tick_cnt <= '0;
               if (rx_s) busy    <= 1'b0;   // glitch, not a start bit
               else      bit_cnt <= 4'd1;
            end else begin
               tick_cnt <= tick_cnt + CW'(1);
            end
         end else if (tick_cnt == CW'(TICK - 1)) begin
            tick_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               busy <= 1'b0;
               if (rx_s) begin
                  o_data           <= shift;
                  o_received_pulse <= 1'b1;
               end
            end else begin
               shift   <= {rx_s, shift[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            tick_cnt <= tick_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte is taken when i_start && o_ready; the line
// idles high and reset cuts any frame in flight.
module uart_tx #(
   parameter int TICK = 217
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx
);
   localparam int CW = $clog2(TICK + 1);

   logic          busy;
   logic [8:0]    shift;
   logic [3:0]    bit_cnt;
   logic [CW-1:0] tick_cnt;

   assign o_ready = !busy;

   // Frame sequencer: bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy     <= 1'b0;
         shift    <= '1;
         bit_cnt  <= '0;
         tick_cnt <= '0;
         o_tx     <= 1'b1;
      end else if (!busy) begin
         o_tx <= 1'b1;
         if (i_start) begin
            busy     <= 1'b1;
            shift    <= {1'b1, i_data};
            bit_cnt  <= '0;
            tick_cnt <= '0;
            o_tx     <= 1'b0;
         end
      end else if (tick_cnt == CW'(TICK - 1)) begin
         tick_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            busy <= 1'b0;
         end else begin
            o_tx    <= shift[0];
            shift   <= {1'b1, shift[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_bus_initiator.sv
// Host-side UART bus initiator: turns local bus requests into protocol bytes
// (bit7=1), completes them from remote responses, and multiplexes a 7-bit user
// stream (bit7=0) on the same link in both directions.
// Optional response timeout: define UART_BUS_INITIATOR_TIMEOUT_EN.
module uart_bus_initiator #(
   parameter int BAUDRATE       = 115200,
   parameter int SYS_FREQ       = 25000000,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cs,
   input  logic        i_we,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_data,
   output logic [7:0]  o_data,
   output logic        o_ack,
   output logic        o_err,
   input  logic [6:0]  i_stream_data,
   input  logic        i_stream_valid,
   output logic        o_stream_ready,
   output logic [6:0]  o_stream_data,
   output logic        o_stream_valid,
   input  logic        i_uart_rx,
   output logic        o_uart_tx
);
   import uart_bus_initiator_pkg::*;

   localparam int TICK = SYS_FREQ / BAUDRATE;

   state_t     state, state_nx;
   req_t       req_q;
   logic [1:0] idx;
   logic [3:0] hi_q;
   logic [7:0] rd_data;

   logic       tx_ready, tx_start, tx_fire;
   logic [7:0] tx_data, proto_byte;
   logic       proto_pend, stream_go;

   logic [7:0] rx_byte;
   logic       rx_pulse;
   cls_t       rx_cls;
   logic [6:0] rx_payload;
   logic       rx_rdata, rx_wack;
   logic [3:0] rx_nib;

   uart_tx #(.TICK(TICK)) u_tx (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_start (tx_start),
      .i_data  (tx_data),
      .o_ready (tx_ready),
      .o_tx    (o_uart_tx)
   );

   uart_rx #(.TICK(TICK)) u_rx (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_rx             (i_uart_rx),
      .o_data           (rx_byte),
      .o_received_pulse (rx_pulse)
   );

   uart_resp_decoder u_dec (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_byte    (rx_byte),
      .i_valid   (rx_pulse),
      .o_cls     (rx_cls),
      .o_payload (rx_payload)
   );

   assign rx_rdata       = (rx_cls == CLS_RDATA);
   assign rx_wack        = (rx_cls == CLS_WACK);
   assign rx_nib         = rx_payload[3:0];
   assign o_stream_valid = (rx_cls == CLS_STREAM);
   assign o_stream_data  = rx_payload;

`ifdef UART_BUS_INITIATOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          timeout_hit;

   // Response watchdog: zero outside the wait states, so it starts at 0 on entry
   always_ff @(posedge i_clk) begin
      if (i_reset)                                           to_cnt <= '0;
      else if (state == ST_WAIT_RESP || state == ST_RESP_LO) to_cnt <= to_cnt + TW'(1);
      else                                                   to_cnt <= '0;
   end

   assign timeout_hit = (state == ST_WAIT_RESP || state == ST_RESP_LO) &&
                        (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nx;
   end

   // FSM next-state logic; unexpected responses simply leave the state alone
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:      if (i_cs) state_nx = ST_SEND_ADDR;
         ST_SEND_ADDR: if (tx_fire && idx == 2'd3)
                          state_nx = req_q.we ? ST_SEND_DATA : ST_SEND_EXEC;
         ST_SEND_DATA: if (tx_fire && idx == 2'd1) state_nx = ST_SEND_EXEC;
         ST_SEND_EXEC: if (tx_fire) state_nx = ST_WAIT_RESP;
         ST_WAIT_RESP: begin
            if (req_q.we && rx_wack)        state_nx = ST_DONE;
            else if (!req_q.we && rx_rdata) state_nx = ST_RESP_LO;
         end
         ST_RESP_LO:   if (rx_rdata) state_nx = ST_DONE;
         ST_DONE:      state_nx = ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
`ifdef UART_BUS_INITIATOR_TIMEOUT_EN
      if (timeout_hit) state_nx = ST_IDLE;
`endif
   end

   // FSM outputs: protocol byte selection, TX arbitration and bus completion
   always_comb begin
      proto_pend = 1'b0;
      proto_byte = 8'h00;
      unique case (state)
         ST_SEND_ADDR: begin
            proto_pend = 1'b1;
            case (idx)
               2'd0:    proto_byte = build_byte(TAG_ADDR, req_q.addr[15:12]);
               2'd1:    proto_byte = build_byte(TAG_ADDR, req_q.addr[11:8]);
               2'd2:    proto_byte = build_byte(TAG_ADDR, req_q.addr[7:4]);
               default: proto_byte = build_byte(TAG_ADDR, req_q.addr[3:0]);
            endcase
         end
         ST_SEND_DATA: begin
            proto_pend = 1'b1;
            proto_byte = build_byte(TAG_DATA, idx[0] ? req_q.data[3:0] : req_q.data[7:4]);
         end
         ST_SEND_EXEC: begin
            proto_pend = 1'b1;
            proto_byte = build_byte(req_q.we ? TAG_EXEC_WR : TAG_EXEC_RD, 4'h0);
         end
         default: ;
      endcase

      // Protocol owns the transmitter whenever it has a byte pending
      tx_fire        = proto_pend && tx_ready;
      stream_go      = i_stream_valid && !proto_pend && tx_ready && !i_reset;
      o_stream_ready = stream_go;
      tx_start       = proto_pend || stream_go;
      tx_data        = proto_pend ? proto_byte : {1'b0, i_stream_data};

      o_ack  = (state == ST_DONE);
      o_err  = 1'b0;
      o_data = rd_data;
`ifdef UART_BUS_INITIATOR_TIMEOUT_EN
      if (timeout_hit) begin
         o_ack  = 1'b1;
         o_err  = 1'b1;
         o_data = 8'hFF;
      end
`endif
   end

   // Request latch, nibble index and read-data assembly
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         req_q   <= '0;
         idx     <= '0;
         hi_q    <= '0;
         rd_data <= 8'h00;
      end else begin
         if (state == ST_IDLE && i_cs) begin
            req_q <= '{we: i_we, addr: i_addr, data: i_data};
            idx   <= '0;
         end else if (tx_fire) begin
            idx <= (state_nx != state) ? 2'd0 : idx + 2'd1;
         end
         if (state == ST_WAIT_RESP && !req_q.we && rx_rdata) hi_q <= rx_nib;
         if (state == ST_RESP_LO && rx_rdata) rd_data <= {hi_q, rx_nib};
      end
   end

endmodule
